// File: rtl/vmw_owire_pkg.sv
// Shared definitions for the open-drain serial transmitter.
package vmw_owire_pkg;

  // Bits per transmitted byte.
  localparam int DATA_W = 8;

  // Bit slots in a frame without parity: one START, eight DATA, one STOP.
  localparam int FRAME_BASE = 10;

  // Frame state sequence; ST_PARITY is only visited when parity is enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Number of bit slots in one frame for a given parity setting.
  function automatic int frame_slots(input int parity_en);
    return FRAME_BASE + parity_en;
  endfunction

endpackage

// File: rtl/vmw_owire_bittimer.sv
// Bit-slot timer: counts 0..BIT_CYCLES-1 and flags the last cycle of a slot.
module vmw_owire_bittimer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic CP,
  input  logic CLRN,
  input  logic restart_i,
  output logic slot_end_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // The final cycle of each slot; with BIT_CYCLES=1 every cycle ends a slot.
  assign slot_end_o = (cnt_q == 8'(BIT_CYCLES - 1));

  // Restart holds the count at zero so the first slot is full length.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    if (restart_i || slot_end_o) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous clear.
  always_ff @(posedge CP) begin
    if (!CLRN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/vmw_owire_tx.sv
// Open-drain one-wire byte transmitter: START, 8 data bits LSB first,
// optional even parity, STOP. E=1 pulls the line low, E=0 releases it.
module vmw_owire_tx
  import vmw_owire_pkg::*;
#(
  parameter int BIT_CYCLES = 4,
  parameter int PARITY_EN  = 0
) (
  input  logic              CP,
  input  logic              CLRN,
  input  logic [DATA_W-1:0] D,
  input  logic              VALID,
  output logic              READY,
  output logic              E,
  output logic              Z,
  output logic              BUSY
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [2:0]          bitcnt_q, bitcnt_d;
  logic                par_q, par_d;
  logic                e_q, e_d;
  logic                slot_end;

  // Timer is held at zero while idle so START gets a full slot.
  vmw_owire_bittimer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .CP        (CP),
    .CLRN      (CLRN),
    .restart_i (state_q == ST_IDLE),
    .slot_end_o(slot_end)
  );

  assign READY = (state_q == ST_IDLE);
  assign BUSY  = (state_q != ST_IDLE);
  assign Z     = 1'b0;
  assign E     = e_q;

  // Next-state logic; E is computed from the next state so it is registered.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    par_d    = par_q;
    e_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (VALID) begin
          state_d  = ST_START;
          shift_d  = D;
          par_d    = ^D;
          bitcnt_d = '0;
        end
      end
      ST_START: begin
        if (slot_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (slot_end) begin
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (slot_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (slot_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_START:  e_d = 1'b1;
      ST_DATA:   e_d = ~shift_d[0];
      ST_PARITY: e_d = ~par_d;
      default:   e_d = 1'b0;
    endcase
  end

  // State and datapath registers; reset aborts any frame and releases the line.
  always_ff @(posedge CP) begin
    if (!CLRN) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      e_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      par_q    <= par_d;
      e_q      <= e_d;
    end
  end

endmodule

// File: tb/tb_vmw_owire_tx.sv
// Testbench for vmw_owire_tx: three instances cover BIT_CYCLES=4 without
// parity, BIT_CYCLES=4 with parity, and BIT_CYCLES=1.
module tb_vmw_owire_tx;
  import vmw_owire_pkg::*;

  logic       clk = 1'b0;
  logic       clrn;
  logic [2:0] valid_s;
  logic [7:0] d_s [3];
  logic [2:0] ready_s, e_s, z_s, busy_s;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vmw_owire_tx #(.BIT_CYCLES(4), .PARITY_EN(0)) dut0 (
    .CP(clk), .CLRN(clrn), .D(d_s[0]), .VALID(valid_s[0]),
    .READY(ready_s[0]), .E(e_s[0]), .Z(z_s[0]), .BUSY(busy_s[0]));
  vmw_owire_tx #(.BIT_CYCLES(4), .PARITY_EN(1)) dut1 (
    .CP(clk), .CLRN(clrn), .D(d_s[1]), .VALID(valid_s[1]),
    .READY(ready_s[1]), .E(e_s[1]), .Z(z_s[1]), .BUSY(busy_s[1]));
  vmw_owire_tx #(.BIT_CYCLES(1), .PARITY_EN(0)) dut2 (
    .CP(clk), .CLRN(clrn), .D(d_s[2]), .VALID(valid_s[2]),
    .READY(ready_s[2]), .E(e_s[2]), .Z(z_s[2]), .BUSY(busy_s[2]));

  // One frame: instance, byte, D value driven after acceptance,
  // slot count, expected E per slot (bit s = slot s).
  typedef struct {
    int          k;
    logic [7:0]  data;
    logic [7:0]  d_after;
    int          slots;
    logic [10:0] epat;
  } vec_t;

  vec_t vecs [8];

  function automatic int bc_of(input int k);
    case (k)
      0, 1:    return 4;
      default: return 1;
    endcase
  endfunction

  // Observed {BUSY, READY, Z, E} of one instance.
  function automatic logic [3:0] status(input int k);
    return {busy_s[k], ready_s[k], z_s[k], e_s[k]};
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {BUSY,READY,Z,E} got %b, want %b", name, act, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where READY is seen high.
  task automatic wait_ready(input int k);
    int n = 0;
    while (!ready_s[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s[k]) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_ready dut%0d: READY got 0, want 1 within 100 cycles", k);
    end
  endtask

  // Entered on the negedge of the first START cycle; checks every frame
  // cycle and the single following IDLE cycle, returning on that negedge.
  task automatic check_frame(input int k, input int slots, input logic [10:0] epat,
                             input string tag);
    int bc = bc_of(k);
    for (int s = 0; s < slots; s++) begin
      for (int c = 0; c < bc; c++) begin
        chk($sformatf("%s slot%0d cyc%0d", tag, s, c), status(k), {3'b100, epat[s]});
        @(negedge clk);
      end
    end
    chk({tag, " idle-after"}, status(k), 4'b0100);
  endtask

  task automatic send(input int k, input logic [7:0] data, input logic [7:0] d_after,
                      input int slots, input logic [10:0] epat, input string tag);
    wait_ready(k);
    valid_s[k] = 1'b1;
    d_s[k]     = data;
    @(negedge clk);
    valid_s[k] = 1'b0;
    d_s[k]     = d_after;
    check_frame(k, slots, epat, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 8'h00, frame_slots(0), 11'h0B5};
    vecs[1] = '{0, 8'h00, 8'h00, frame_slots(0), 11'h1FF};
    vecs[2] = '{0, 8'hFF, 8'h00, frame_slots(0), 11'h001};
    vecs[3] = '{0, 8'h3C, 8'hC3, frame_slots(0), 11'h187};
    vecs[4] = '{1, 8'h07, 8'h00, frame_slots(1), 11'h1F1};
    vecs[5] = '{1, 8'h03, 8'h00, frame_slots(1), 11'h3F9};
    vecs[6] = '{2, 8'hFF, 8'h00, frame_slots(0), 11'h001};
    vecs[7] = '{2, 8'h5A, 8'h00, frame_slots(0), 11'h14B};

    clrn    = 1'b0;
    valid_s = '0;
    for (int k = 0; k < 3; k++) d_s[k] = 8'h00;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("reset dut%0d", k), status(k), 4'b0100);
    clrn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].k, vecs[i].data, vecs[i].d_after, vecs[i].slots, vecs[i].epat,
           $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // VALID held high across two frames.
    wait_ready(0);
    valid_s[0] = 1'b1;
    d_s[0]     = 8'h55;
    @(negedge clk);
    d_s[0] = 8'hAA;
    check_frame(0, 10, 11'h155, "b2b-first");
    @(negedge clk);
    valid_s[0] = 1'b0;
    check_frame(0, 10, 11'h0AB, "b2b-second");
    @(negedge clk);

    // Reset during data bit 3 (frame cycles 17..20), then a clean frame.
    wait_ready(0);
    valid_s[0] = 1'b1;
    d_s[0]     = 8'hF0;
    @(negedge clk);
    valid_s[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre-reset bit3", status(0), 4'b1001);
    clrn = 1'b0;
    @(negedge clk);
    chk("mid-frame reset", status(0), 4'b0100);
    clrn = 1'b1;
    send(0, 8'h0F, 8'h00, 10, 11'h1E1, "post-reset");
    @(negedge clk);

    // Reset wins over a simultaneous acceptance.
    wait_ready(0);
    clrn       = 1'b0;
    valid_s[0] = 1'b1;
    d_s[0]     = 8'h00;
    @(negedge clk);
    chk("reset-prio", status(0), 4'b0100);
    valid_s[0] = 1'b0;
    clrn       = 1'b1;
    @(negedge clk);
    chk("reset-prio no-frame", status(0), 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
